// File: rtl/bus_arb_pkg.sv
// Shared types and width helpers for the round-robin bus arbiter.
package bus_arb_pkg;

  typedef logic [0:0] state_t;

  localparam state_t IDLE  = 1'b0;
  localparam state_t OWNED = 1'b1;

  // Reset value of the round-robin pointer, so requester 0 wins the first arbitration
  function automatic int unsigned rr_ptr_reset(input int unsigned num_req);
    return num_req - 1;
  endfunction

  function automatic int unsigned id_width(input int unsigned num_req);
    return (num_req < 2) ? 1 : $clog2(num_req);
  endfunction

  function automatic int unsigned cnt_width(input int unsigned max_hold);
    return $clog2(max_hold) + 1;
  endfunction

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester strictly after ptr, with wrap.
module rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] pick,
  output logic [ID_W-1:0]    pick_id,
  output logic               any
);

  // Upper pass covers indices above ptr, lower pass wraps to 0..ptr
  always_comb begin
    pick    = '0;
    pick_id = '0;
    any     = 1'b0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (!any && req[j] && (j > 32'(ptr))) begin
        any     = 1'b1;
        pick[j] = 1'b1;
        pick_id = ID_W'(j);
      end
    end
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (!any && req[j] && (j <= 32'(ptr))) begin
        any     = 1'b1;
        pick[j] = 1'b1;
        pick_id = ID_W'(j);
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter with capped multi-cycle tenures and BusMuxOut source mux.
// Optional: BUS_ARB_PRIORITY_EN gives requester 0 precedence at every arbitration point.
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_HOLD   = 4
) (
  input  logic                          clk,
  input  logic                          clear,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            hold,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] src_data,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          grant_valid,
  output logic [id_width(NUM_REQ)-1:0]  grant_id,
  output logic [DATA_WIDTH-1:0]         BusMuxOut
);

  localparam int unsigned ID_W  = id_width(NUM_REQ);
  localparam int unsigned CNT_W = cnt_width(MAX_HOLD);
  localparam logic [ID_W-1:0]  RR_PTR_RESET = ID_W'(rr_ptr_reset(NUM_REQ));
  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(MAX_HOLD - 1);

  state_t               state, state_n;
  logic [NUM_REQ-1:0]   grant_n;
  logic                 grant_valid_n;
  logic [ID_W-1:0]      grant_id_n;
  logic [CNT_W-1:0]     hold_cnt, hold_cnt_n;
  logic [ID_W-1:0]      rr_ptr, rr_ptr_n;

  logic [ID_W-1:0]      pick_ptr;
  logic [NUM_REQ-1:0]   pick;
  logic [ID_W-1:0]      pick_id;
  logic                 pick_any;
  logic [NUM_REQ-1:0]   win;
  logic [ID_W-1:0]      win_id;
  logic                 prio_win;
  logic                 rel_now;

  // At a release the search starts after the current owner, so it comes last
  assign pick_ptr = (state == OWNED) ? grant_id : rr_ptr;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .req     (req),
    .ptr     (pick_ptr),
    .pick    (pick),
    .pick_id (pick_id),
    .any     (pick_any)
  );

  // Next-state and next-grant decision
  always_comb begin
    state_n       = state;
    grant_n       = grant;
    grant_valid_n = grant_valid;
    grant_id_n    = grant_id;
    hold_cnt_n    = hold_cnt;
    rr_ptr_n      = rr_ptr;
    win           = pick;
    win_id        = pick_id;
    prio_win      = 1'b0;
`ifdef BUS_ARB_PRIORITY_EN
    if (req[0]) begin
      win      = NUM_REQ'(1);
      win_id   = '0;
      prio_win = 1'b1;
    end
`else
    prio_win = 1'b0;
`endif
    rel_now = !(|(req & grant)) || !(|(hold & grant)) || (hold_cnt == HOLD_LAST);

    case (state)
      IDLE: begin
        if (pick_any) begin
          state_n       = OWNED;
          grant_n       = win;
          grant_valid_n = 1'b1;
          grant_id_n    = win_id;
          hold_cnt_n    = '0;
        end
      end
      OWNED: begin
        if (rel_now) begin
          if (!prio_win) rr_ptr_n = grant_id;
          if (pick_any) begin
            grant_n       = win;
            grant_valid_n = 1'b1;
            grant_id_n    = win_id;
            hold_cnt_n    = '0;
          end else begin
            state_n       = IDLE;
            grant_n       = '0;
            grant_valid_n = 1'b0;
            grant_id_n    = '0;
            hold_cnt_n    = '0;
          end
        end else begin
          hold_cnt_n = hold_cnt + CNT_W'(1);
        end
      end
      default: begin
        state_n       = IDLE;
        grant_n       = '0;
        grant_valid_n = 1'b0;
        grant_id_n    = '0;
        hold_cnt_n    = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clear) begin
      state       <= IDLE;
      grant       <= '0;
      grant_valid <= 1'b0;
      grant_id    <= '0;
      hold_cnt    <= '0;
      rr_ptr      <= RR_PTR_RESET;
    end else begin
      state       <= state_n;
      grant       <= grant_n;
      grant_valid <= grant_valid_n;
      grant_id    <= grant_id_n;
      hold_cnt    <= hold_cnt_n;
      rr_ptr      <= rr_ptr_n;
    end
  end

  // Bus mux driven only by the registered one-hot grant; idle yields zero
  always_comb begin
    BusMuxOut = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) BusMuxOut = BusMuxOut | src_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: stimulus pushes expected grants, a monitor pops and compares.
module tb_bus_arbiter;

  logic         clk;
  logic         clear;
  logic [3:0]   req;
  logic [3:0]   hold;
  logic [127:0] src_data;
  logic [3:0]   grant;
  logic         grant_valid;
  logic [1:0]   grant_id;
  logic [31:0]  BusMuxOut;

  typedef struct {
    logic [3:0] g;
    string      nm;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  bus_arbiter #(
    .NUM_REQ    (4),
    .DATA_WIDTH (32),
    .MAX_HOLD   (4)
  ) dut (
    .clk         (clk),
    .clear       (clear),
    .req         (req),
    .hold        (hold),
    .src_data    (src_data),
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_id    (grant_id),
    .BusMuxOut   (BusMuxOut)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [1:0] exp_id(input logic [3:0] g);
    case (g)
      4'b0010: return 2'd1;
      4'b0100: return 2'd2;
      4'b1000: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  function automatic logic [31:0] exp_bus(input logic [3:0] g);
    case (g)
      4'b0001: return 32'hAAAA_0000;
      4'b0010: return 32'h1111_2222;
      4'b0100: return 32'hDEAD_BEEF;
      4'b1000: return 32'h0000_0005;
      default: return 32'h0;
    endcase
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Drive one cycle of inputs and record the grant expected after the next edge
  task automatic step(input logic c, input logic [3:0] r, input logic [3:0] h,
                      input logic [3:0] g, input string nm);
    @(negedge clk);
    clear = c;
    req   = r;
    hold  = h;
    q.push_back('{g: g, nm: nm});
  endtask

  // Monitor: compares registered outputs shortly after each rising edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        check({e.nm, ".grant"}, 32'(grant), 32'(e.g));
        check({e.nm, ".valid"}, 32'(grant_valid), 32'(e.g != 4'b0000));
        check({e.nm, ".id"}, 32'(grant_id), 32'(exp_id(e.g)));
        check({e.nm, ".bus"}, BusMuxOut, exp_bus(e.g));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    clear    = 1'b0;
    req      = 4'b0000;
    hold     = 4'b0000;
    src_data = {32'h0000_0005, 32'hDEAD_BEEF, 32'h1111_2222, 32'hAAAA_0000};

    // Reset with all requesting, then first grant after release of clear
    step(1'b0, 4'b1111, 4'b0000, 4'b0000, "rst0");
    step(1'b0, 4'b1111, 4'b0000, 4'b0000, "rst1");
    step(1'b1, 4'b1111, 4'b0000, 4'b0001, "rot0");
`ifdef BUS_ARB_PRIORITY_EN
    step(1'b1, 4'b1111, 4'b0000, 4'b0001, "prio1");
    step(1'b1, 4'b1111, 4'b0000, 4'b0001, "prio2");
    step(1'b1, 4'b1111, 4'b0000, 4'b0001, "prio3");
    step(1'b1, 4'b1111, 4'b0000, 4'b0001, "prio4");
`else
    step(1'b1, 4'b1111, 4'b0000, 4'b0010, "rot1");
    step(1'b1, 4'b1111, 4'b0000, 4'b0100, "rot2");
    step(1'b1, 4'b1111, 4'b0000, 4'b1000, "rot3");
    step(1'b1, 4'b1111, 4'b0000, 4'b0001, "rot4");
`endif

    // Sparse requesters rotate with wrap
    step(1'b1, 4'b1010, 4'b0000, 4'b0010, "part0");
    step(1'b1, 4'b1010, 4'b0000, 4'b1000, "part1");
    step(1'b1, 4'b1010, 4'b0000, 4'b0010, "part2");
    step(1'b1, 4'b0000, 4'b0000, 4'b0000, "idle");

    // Hold cap: requester 0 keeps the bus for MAX_HOLD cycles
    step(1'b0, 4'b0011, 4'b0001, 4'b0000, "hc_rst");
    step(1'b1, 4'b0011, 4'b0001, 4'b0001, "hc1");
    step(1'b1, 4'b0011, 4'b0001, 4'b0001, "hc2");
    step(1'b1, 4'b0011, 4'b0001, 4'b0001, "hc3");
    step(1'b1, 4'b0011, 4'b0001, 4'b0001, "hc4");
`ifdef BUS_ARB_PRIORITY_EN
    step(1'b1, 4'b0011, 4'b0001, 4'b0001, "hc5");
`else
    step(1'b1, 4'b0011, 4'b0001, 4'b0010, "hc5");
`endif
    step(1'b1, 4'b0011, 4'b0001, 4'b0001, "hc6");

    // Sole requester is re-granted across the cap without a gap
    step(1'b0, 4'b0000, 4'b0000, 4'b0000, "sole_rst");
    for (int k = 0; k < 6; k++)
      step(1'b1, 4'b0001, 4'b0001, 4'b0001, $sformatf("sole%0d", k));

    // Early release by dropping req; data mux shows slice 2 while owned
    step(1'b0, 4'b0000, 4'b0000, 4'b0000, "er_rst");
    step(1'b1, 4'b0100, 4'b0100, 4'b0100, "er1");
    step(1'b1, 4'b0100, 4'b0100, 4'b0100, "er2");
    step(1'b1, 4'b0000, 4'b0000, 4'b0000, "er_drop");

    // Reset pulsed mid-tenure
    step(1'b1, 4'b0100, 4'b0100, 4'b0100, "mt1");
    step(1'b0, 4'b0100, 4'b0100, 4'b0000, "mt_clr");
    step(1'b1, 4'b0100, 4'b0100, 4'b0100, "mt_again");
    step(1'b1, 4'b0000, 4'b0000, 4'b0000, "mt_idle");

    repeat (3) @(posedge clk);
    #3;
    check("queue_drained", 32'(q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Round-robin arbiter that shares the 32-bit internal bus among NUM_REQ bus sources (registers, ALU result, memory data).
- Registers a one-hot grant and drives BusMuxOut from the granted source; destination registers load from it with their own enables.
- Supports multi-cycle tenures through a per-requester hold line, capped at MAX_HOLD cycles.

Parameters:
- NUM_REQ, 4, number of bus requesters; must be ≥2.
- DATA_WIDTH, 32, bus width in bits.
- MAX_HOLD, 4, maximum consecutive cycles in one tenure; must be ≥1.

Ports:
- clk  input  1  rising-edge clock.
- clear  input  1  synchronous reset, active-low: clear=0 resets on the next rising edge of clk.
- req  input  NUM_REQ  request per source; level-sensitive.
- hold  input  NUM_REQ  owner asks to extend its tenure; ignored for non-owners.
- src_data  input  NUM_REQ*DATA_WIDTH  packed source data; slice i is [i*DATA_WIDTH +: DATA_WIDTH].
- grant  output  NUM_REQ  registered one-hot grant.
- grant_valid  output  1  registered; high when any grant bit is set.
- grant_id  output  $clog2(NUM_REQ)  registered binary index of the owner; 0 when idle.
- BusMuxOut  output  DATA_WIDTH  src_data slice of the owner when grant_valid=1, else all zeros. Combinational from the registered grant only.

Behaviour:
- Reset (clear=0): state=IDLE, grant=0, grant_valid=0, grant_id=0, hold_cnt=0, rr_ptr=NUM_REQ-1. BusMuxOut=0 follows.
- clear=0 overrides every other input in the same cycle, including mid-tenure.
- States are IDLE and OWNED.
- IDLE:
  - If req≠0 at the edge, grant the first requester after rr_ptr, searching upward with wrap.
  - Go to OWNED with hold_cnt=0. Latency from req sampled to grant visible is 1 cycle.
  - If req=0, stay in IDLE.
- OWNED, owner o. Release at the edge when any of these holds:
  - req[o]=0, or
  - hold[o]=0, or
  - hold_cnt==MAX_HOLD-1.
- OWNED, no release: keep grant and increment hold_cnt.
- OWNED, on release:
  - rr_ptr←o.
  - If req≠0 at the same edge, grant the next requester after o (o itself last) and reset hold_cnt=0. No idle bubble.
  - Otherwise go to IDLE with grant=0.
- If the owner is the sole requester at release, it is re-granted as a new tenure: hold_cnt=0, grant stays high without a gap.
- MAX_HOLD=1: every cycle is a release and arbitration point.
- Every tenure lasts ≥1 cycle. grant is never multi-hot. grant_id always encodes grant.
- req bits that rise mid-tenure wait for the next release. The arbiter never preempts.
- hold_cnt width is $clog2(MAX_HOLD)+1, so it cannot overflow.

Optional Feature:
- Macro BUS_ARB_PRIORITY_EN.
- Defined: at every arbitration point (IDLE with req≠0, or a release), req[0]=1 wins over the round-robin choice and rr_ptr is left unchanged. Requester 0 still cannot preempt an ongoing tenure and is still subject to MAX_HOLD.
- Not defined: pure round-robin; requester 0 has no special status.

Decomposition:
- Package bus_arb_pkg holds:
  - state typedef (IDLE, OWNED);
  - RR_PTR_RESET constant;
  - width helper function for hold_cnt and grant_id.
- Sub-module rr_pick: combinational round-robin picker.
  - Inputs: req, ptr. Outputs: one-hot pick, pick_id, any.
  - Used for both the IDLE and release decisions.
- The top level holds the FSM, hold_cnt, rr_ptr, and the BusMuxOut mux.

Test Plan:
- Reset: clear=0 for 2 cycles with req=4'b1111 → grant=0, grant_valid=0, BusMuxOut=0. Then clear=1 → one cycle later grant=4'b0001, grant_id=0.
- Rotation: req=4'b1111, hold=0 → grant sequence 0001,0010,0100,1000,0001 on consecutive cycles, grant_valid held at 1, no bubble.
- Hold cap: req=4'b0011, hold=4'b0001 → grant 0001 for exactly 4 cycles, then 0010 for 1 cycle, then 0001 again.
- Early release and mid-tenure reset:
  - req=4'b0100, hold=4'b0100; drop req[2] after 2 cycles → next cycle grant=0, grant_valid=0.
  - Repeat with clear=0 pulsed on the 2nd tenure cycle → grant=0 on the next edge.
- Data mux: src_data slices = 32'hAAAA0000, 32'h1111_2222, 32'hDEADBEEF, 32'h0000_0005, with grant=0100 → BusMuxOut=32'hDEADBEEF. When idle → 32'h0.
- Priority, with BUS_ARB_PRIORITY_EN defined: req=4'b1111, hold=0 → grant 0001 every cycle, rr_ptr unchanged. Without the macro, the same stimulus rotates as in the rotation scenario.
